// File: rtl/wishbone_vga_fill_master.sv
// rtl/wishbone_vga_fill_master.sv - Wishbone classic write master that block-fills VGA frame memory
// Writes a constant or incrementing 32-bit pattern, one single-beat transfer per word.
module wishbone_vga_fill_master #(
   parameter int ADR_W          = 12,
   parameter int CNT_W          = 13,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [ADR_W-1:0] base_adr_i,
   input  logic [CNT_W-1:0] count_i,
   input  logic [31:0]      fill_dat_i,
   input  logic [31:0]      data_step_i,
   input  logic [3:0]       fill_sel_i,
   output logic             wb_cyc_o,
   output logic             wb_stb_o,
   output logic             wb_we_o,
   output logic [3:0]       wb_sel_o,
   output logic [ADR_W-1:0] wb_adr_o,
   output logic [31:0]      wb_dat_o,
   input  logic             wb_ack_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             timeout_o,
   output logic [CNT_W-1:0] beats_o
);

   localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic {IDLE, WRITE} state_t;

   state_t            state;
   logic [CNT_W-1:0]  remaining;
   logic [31:0]       step_q;
   logic              abort_flag;
   logic [WAIT_W-1:0] wait_cnt;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state      <= IDLE;
         wb_cyc_o   <= 1'b0;
         wb_stb_o   <= 1'b0;
         wb_we_o    <= 1'b0;
         wb_sel_o   <= '0;
         wb_adr_o   <= '0;
         wb_dat_o   <= '0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         timeout_o  <= 1'b0;
         beats_o    <= '0;
         remaining  <= '0;
         step_q     <= '0;
         abort_flag <= 1'b0;
         wait_cnt   <= '0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  beats_o    <= '0;
                  timeout_o  <= 1'b0;
                  abort_flag <= 1'b0;
                  wait_cnt   <= '0;
                  if (count_i != '0) begin
                     wb_cyc_o  <= 1'b1;
                     wb_stb_o  <= 1'b1;
                     wb_we_o   <= 1'b1;
                     wb_adr_o  <= base_adr_i;
                     wb_dat_o  <= fill_dat_i;
                     wb_sel_o  <= fill_sel_i;
                     step_q    <= data_step_i;
                     remaining <= count_i;
                     busy_o    <= 1'b1;
                     state     <= WRITE;
                  end else begin
                     done_o <= 1'b1;
                  end
               end
            end
            WRITE: begin
               if (abort_i)
                  abort_flag <= 1'b1;
               if (wb_stb_o && wb_ack_i) begin
                  beats_o   <= beats_o + CNT_W'(1);
                  remaining <= remaining - CNT_W'(1);
                  // an abort arriving on the ack edge still ends the job after this beat
                  if (remaining == CNT_W'(1) || abort_flag || abort_i) begin
                     wb_cyc_o <= 1'b0;
                     wb_stb_o <= 1'b0;
                     wb_we_o  <= 1'b0;
                     busy_o   <= 1'b0;
                     done_o   <= 1'b1;
                     state    <= IDLE;
                  end else begin
                     wb_adr_o <= wb_adr_o + ADR_W'(1);
                     wb_dat_o <= wb_dat_o + step_q;
                     wait_cnt <= '0;
                  end
               end else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                  wb_cyc_o  <= 1'b0;
                  wb_stb_o  <= 1'b0;
                  wb_we_o   <= 1'b0;
                  busy_o    <= 1'b0;
                  done_o    <= 1'b1;
                  timeout_o <= 1'b1;
                  state     <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wishbone_vga_fill_master.sv
// tb/tb_wishbone_vga_fill_master.sv - directed bench for wishbone_vga_fill_master
module tb_wishbone_vga_fill_master;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [11:0] base_adr = '0;
   logic [12:0] count = '0;
   logic [31:0] fill_dat = '0;
   logic [31:0] data_step = '0;
   logic [3:0]  fill_sel = '0;
   logic        wb_cyc, wb_stb, wb_we, wb_ack;
   logic [3:0]  wb_sel;
   logic [11:0] wb_adr;
   logic [31:0] wb_dat;
   logic        busy, done, timeout;
   logic [12:0] beats;

   int total = 0;
   int fails = 0;
   logic        resp_en = 1'b1;
   int          done_cnt = 0;
   logic        cyc_seen = 1'b0;
   logic        busy_seen = 1'b0;
   int          stb_cycles = 0;
   logic [11:0] log_adr[$];
   logic [31:0] log_dat[$];

   wishbone_vga_fill_master dut (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .abort_i(abort),
      .base_adr_i(base_adr), .count_i(count), .fill_dat_i(fill_dat),
      .data_step_i(data_step), .fill_sel_i(fill_sel),
      .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_sel_o(wb_sel),
      .wb_adr_o(wb_adr), .wb_dat_o(wb_dat), .wb_ack_i(wb_ack),
      .busy_o(busy), .done_o(done), .timeout_o(timeout), .beats_o(beats)
   );

   always #5 clk = ~clk;

   // registered responder that never re-acks on consecutive cycles
   always @(posedge clk) wb_ack <= resp_en & wb_cyc & wb_stb & ~wb_ack;
   initial wb_ack = 1'b0;

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (wb_cyc) cyc_seen = 1'b1;
      if (busy) busy_seen = 1'b1;
      if (wb_stb) stb_cycles++;
      if (wb_cyc && wb_stb && wb_ack) begin
         log_adr.push_back(wb_adr);
         log_dat.push_back(wb_dat);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      done_cnt = 0; cyc_seen = 1'b0; busy_seen = 1'b0; stb_cycles = 0;
      log_adr.delete(); log_dat.delete();
   endtask

   // drives start for one cycle; returns at the negedge after the sampling edge
   task automatic do_start(input logic [11:0] b, input logic [12:0] c, input logic [31:0] d,
                           input logic [31:0] s, input logic [3:0] sl);
      @(negedge clk);
      base_adr = b; count = c; fill_dat = d; data_step = s; fill_sel = sl; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int max_cycles);
      int n = 0;
      while (done_cnt == 0 && n < max_cycles) begin
         @(negedge clk);
         n++;
      end
      chk(tag, (done_cnt != 0) ? 32'd1 : 32'd0, 32'd1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int n;
      repeat (2) @(negedge clk);
      chk("rst_cyc", {31'd0, wb_cyc}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_beats", {19'd0, beats}, 32'd0);
      chk("rst_adr", {20'd0, wb_adr}, 32'd0);
      rst_n = 1'b1;

      // constant fill
      clear_mon();
      do_start(12'h010, 13'd4, 32'h00000F0F, 32'd0, 4'hF);
      chk("c_first_adr", {20'd0, wb_adr}, 32'h010);
      chk("c_sel", {28'd0, wb_sel}, 32'hF);
      chk("c_we", {31'd0, wb_we}, 32'd1);
      wait_done("c_done_wait", 50);
      chk("c_nwr", log_adr.size(), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("c_adr%0d", i), {20'd0, log_adr[i]}, 32'h010 + i);
         chk($sformatf("c_dat%0d", i), log_dat[i], 32'h00000F0F);
      end
      chk("c_done_cnt", done_cnt, 32'd1);
      chk("c_beats", {19'd0, beats}, 32'd4);
      chk("c_busy", {31'd0, busy}, 32'd0);

      // incrementing data with address wrap
      clear_mon();
      do_start(12'hFFE, 13'd3, 32'h10, 32'd2, 4'h3);
      wait_done("w_done_wait", 50);
      chk("w_nwr", log_adr.size(), 32'd3);
      chk("w_adr0", {20'd0, log_adr[0]}, 32'hFFE);
      chk("w_dat0", log_dat[0], 32'h10);
      chk("w_adr1", {20'd0, log_adr[1]}, 32'hFFF);
      chk("w_dat1", log_dat[1], 32'h12);
      chk("w_adr2", {20'd0, log_adr[2]}, 32'h000);
      chk("w_dat2", log_dat[2], 32'h14);
      chk("w_beats", {19'd0, beats}, 32'd3);

      // zero count
      clear_mon();
      do_start(12'h123, 13'd0, 32'h1, 32'd0, 4'hF);
      chk("z_done_pulse", {31'd0, done}, 32'd1);
      @(negedge clk);
      chk("z_done_low", {31'd0, done}, 32'd0);
      repeat (3) @(negedge clk);
      chk("z_cyc_seen", {31'd0, cyc_seen}, 32'd0);
      chk("z_busy_seen", {31'd0, busy_seen}, 32'd0);
      chk("z_done_cnt", done_cnt, 32'd1);
      chk("z_beats", {19'd0, beats}, 32'd0);

      // abort during beat 5, with an ignored start while busy
      clear_mon();
      do_start(12'h200, 13'd100, 32'hA0, 32'd1, 4'hF);
      @(negedge clk);
      base_adr = 12'h700; count = 13'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (beats != 13'd4 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("a_reach_beat5", {19'd0, beats}, 32'd4);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_done("a_done_wait", 20);
      chk("a_beats", {19'd0, beats}, 32'd5);
      chk("a_nwr", log_adr.size(), 32'd5);
      chk("a_first_adr", {20'd0, log_adr[0]}, 32'h200);
      chk("a_last_adr", {20'd0, log_adr[4]}, 32'h204);
      chk("a_last_dat", log_dat[4], 32'hA4);
      chk("a_done_cnt", done_cnt, 32'd1);
      chk("a_busy", {31'd0, busy}, 32'd0);

      // timeout with a silent responder
      resp_en = 1'b0;
      clear_mon();
      do_start(12'h050, 13'd8, 32'h5, 32'd0, 4'hF);
      wait_done("t_done_wait", 400);
      chk("t_stb_cycles", stb_cycles, 32'd255);
      chk("t_timeout", {31'd0, timeout}, 32'd1);
      chk("t_beats", {19'd0, beats}, 32'd0);
      chk("t_done_cnt", done_cnt, 32'd1);
      chk("t_cyc", {31'd0, wb_cyc}, 32'd0);
      resp_en = 1'b1;
      clear_mon();
      do_start(12'h060, 13'd1, 32'h6, 32'd0, 4'hF);
      chk("t_cleared", {31'd0, timeout}, 32'd0);
      wait_done("t2_done_wait", 20);
      chk("t2_beats", {19'd0, beats}, 32'd1);

      // reset mid-job
      clear_mon();
      do_start(12'h300, 13'd10, 32'h0, 32'd1, 4'hF);
      n = 0;
      while (beats != 13'd1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      rst_n = 1'b0;
      #1;
      chk("r_cyc", {31'd0, wb_cyc}, 32'd0);
      chk("r_stb", {31'd0, wb_stb}, 32'd0);
      chk("r_busy", {31'd0, busy}, 32'd0);
      chk("r_beats", {19'd0, beats}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("r_no_done", done_cnt, 32'd0);
      clear_mon();
      do_start(12'h100, 13'd2, 32'h5, 32'd1, 4'hC);
      wait_done("r2_done_wait", 20);
      chk("r2_nwr", log_adr.size(), 32'd2);
      chk("r2_adr1", {20'd0, log_adr[1]}, 32'h101);
      chk("r2_dat1", log_dat[1], 32'h6);
      chk("r2_beats", {19'd0, beats}, 32'd2);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
